mem_arbiter: RTL and testbench

//   Two-port arbiter that shares the single-port system RAM between the CPU

---
 rtl/mem_arbiter_if.sv | 23 ++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle for one arbiter port (CPU or DMA).
// The requester uses the master modport; the arbiter uses slave.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between the CPU memory path and a DMA/loader port.
// One access per grant, one-cycle ack to the winner, IDLE gap between grants.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 9,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned CPU_PRIORITY = 0
) (
    input  logic              Clock,
    input  logic              Reset,
    mem_arbiter_if.slave      cpu_if,
    mem_arbiter_if.slave      dma_if,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic              ram_we_o,
    output logic              ram_re_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              busy_o,
    output logic              owner_o
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StAck} state_e;

    localparam logic [2:0] LatInit = 3'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              grant_dma;

    // DMA wins alone, or on a tie when round-robin and the CPU had the last grant.
    always_comb begin
        grant_dma = dma_if.req && (!cpu_if.req || (CPU_PRIORITY == 0 && !last_q));
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_if.req || dma_if.req) begin
                    owner_d = grant_dma;
                    last_d  = grant_dma;
                    we_d    = grant_dma ? dma_if.we    : cpu_if.we;
                    addr_d  = grant_dma ? dma_if.addr  : cpu_if.addr;
                    wdata_d = grant_dma ? dma_if.wdata : cpu_if.wdata;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (we_q) begin
                    state_d = StAck;
                end else begin
                    cnt_d   = LatInit;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    if (owner_q) dma_rdata_d = ram_rdata_i;
                    else         cpu_rdata_d = ram_rdata_i;
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // last_q resets to DMA so the CPU wins the first tie.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= 3'd0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Strobes decode straight from state so an async reset kills them at once.
    always_comb begin
        ram_we_o    = (state_q == StAccess) && we_q;
        ram_re_o    = (state_q == StAccess) && !we_q;
        ram_addr_o  = (state_q == StAccess || state_q == StWait) ? addr_q : '0;
        ram_wdata_o = ram_we_o ? wdata_q : '0;
        busy_o      = (state_q != StIdle);
        owner_o     = owner_q;
    end

    assign cpu_if.ack   = (state_q == StAck) && !owner_q;
    assign dma_if.ack   = (state_q == StAck) && owner_q;
    assign cpu_if.rdata = cpu_rdata_q;
    assign dma_if.rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: dut0 is round-robin with RD_LAT=2, dut1 is CPU-priority with RD_LAT=1.
// Stimulus pushes expected RAM strobes and acks; a negedge monitor pops and compares.
module tb_mem_arbiter;

    typedef struct {
        int          cyc;
        logic        port;
        logic [31:0] crd;
        logic [31:0] drd;
    } ack_t;

    typedef struct {
        int          cyc;
        logic        we;
        logic [8:0]  addr;
        logic [31:0] data;
    } ram_t;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   cyc   = 0;
    bit   done  = 1'b0;
    int   passes = 0;
    int   total  = 0;

    ack_t ackq0[$];
    ack_t ackq1[$];
    ram_t ramq0[$];
    ram_t ramq1[$];

    mem_arbiter_if c0 ();
    mem_arbiter_if d0 ();
    mem_arbiter_if c1 ();
    mem_arbiter_if d1 ();

    logic [8:0]  r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata;
    logic        r0_we, r0_re, r1_we, r1_re;
    logic        busy0, busy1, own0, own1;

    mem_arbiter #(.RD_LAT(2), .CPU_PRIORITY(0)) dut0 (
        .Clock       (Clock),
        .Reset       (Reset),
        .cpu_if      (c0),
        .dma_if      (d0),
        .ram_addr_o  (r0_addr),
        .ram_wdata_o (r0_wdata),
        .ram_we_o    (r0_we),
        .ram_re_o    (r0_re),
        .ram_rdata_i (r0_rdata),
        .busy_o      (busy0),
        .owner_o     (own0)
    );

    mem_arbiter #(.RD_LAT(1), .CPU_PRIORITY(1)) dut1 (
        .Clock       (Clock),
        .Reset       (Reset),
        .cpu_if      (c1),
        .dma_if      (d1),
        .ram_addr_o  (r1_addr),
        .ram_wdata_o (r1_wdata),
        .ram_we_o    (r1_we),
        .ram_re_o    (r1_re),
        .ram_rdata_i (r1_rdata),
        .busy_o      (busy1),
        .owner_o     (own1)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // RAM models: read data appears RD_LAT cycles after the read strobe.
    logic [31:0] mem0 [512];
    logic [31:0] mem1 [512];
    logic [31:0] p0a = '0, p0b = '0, p1a = '0;

    always @(posedge Clock) begin
        if (Reset) begin
            mem0[9'h010] <= 32'h1234_5678;
            mem1[9'h030] <= 32'hCAFE_F00D;
        end
        if (r0_we) mem0[r0_addr] <= r0_wdata;
        if (r0_re) p0a <= mem0[r0_addr];
        p0b <= p0a;
        if (r1_we) mem1[r1_addr] <= r1_wdata;
        if (r1_re) p1a <= mem1[r1_addr];
    end

    assign r0_rdata = p0b;
    assign r1_rdata = p1a;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act === want) passes++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, want, cyc);
    endtask

    task automatic exp_ack(input int d, input int cy, input logic p, input logic [31:0] crd,
                           input logic [31:0] drd);
        if (d == 0) ackq0.push_back('{cyc: cy, port: p, crd: crd, drd: drd});
        else        ackq1.push_back('{cyc: cy, port: p, crd: crd, drd: drd});
    endtask

    task automatic exp_ram(input int d, input int cy, input logic we, input logic [8:0] addr,
                           input logic [31:0] data);
        if (d == 0) ramq0.push_back('{cyc: cy, we: we, addr: addr, data: data});
        else        ramq1.push_back('{cyc: cy, we: we, addr: addr, data: data});
    endtask

    task automatic mon_ack(input int d, input logic ca, input logic da, input logic own,
                           input logic [31:0] crd, input logic [31:0] drd);
        ack_t e;
        if (!(ca || da)) return;
        if ((d == 0 && ackq0.size() == 0) || (d == 1 && ackq1.size() == 0)) begin
            chk($sformatf("dut%0d unexpected ack", d), 32'({ca, da}), 32'd0);
            return;
        end
        if (d == 0) e = ackq0.pop_front();
        else        e = ackq1.pop_front();
        chk($sformatf("dut%0d ack cycle", d), 32'(cyc), 32'(e.cyc));
        chk($sformatf("dut%0d ack port {cpu,dma}", d), 32'({ca, da}),
            e.port ? 32'd1 : 32'd2);
        chk($sformatf("dut%0d owner at ack", d), 32'(own), 32'(e.port));
        chk($sformatf("dut%0d cpu_rdata at ack", d), crd, e.crd);
        chk($sformatf("dut%0d dma_rdata at ack", d), drd, e.drd);
    endtask

    task automatic mon_ram(input int d, input logic we, input logic re, input logic [8:0] addr,
                           input logic [31:0] wdata);
        ram_t e;
        if (!(we || re)) return;
        if ((d == 0 && ramq0.size() == 0) || (d == 1 && ramq1.size() == 0)) begin
            chk($sformatf("dut%0d unexpected ram strobe", d), 32'({we, re}), 32'd0);
            return;
        end
        if (d == 0) e = ramq0.pop_front();
        else        e = ramq1.pop_front();
        chk($sformatf("dut%0d ram strobe cycle", d), 32'(cyc), 32'(e.cyc));
        chk($sformatf("dut%0d ram {we,re}", d), 32'({we, re}), e.we ? 32'd2 : 32'd1);
        chk($sformatf("dut%0d ram_addr", d), 32'(addr), 32'(e.addr));
        if (e.we) chk($sformatf("dut%0d ram_wdata", d), wdata, e.data);
    endtask

    task automatic rst_chk(input int d, input logic busy, input logic own, input logic ca,
                           input logic da, input logic [31:0] crd, input logic [31:0] drd,
                           input logic [8:0] addr, input logic we, input logic re);
        chk($sformatf("dut%0d busy in reset", d), 32'(busy), 32'd0);
        chk($sformatf("dut%0d owner in reset", d), 32'(own), 32'd0);
        chk($sformatf("dut%0d acks in reset", d), 32'({ca, da}), 32'd0);
        chk($sformatf("dut%0d ram strobes in reset", d), 32'({we, re}), 32'd0);
        chk($sformatf("dut%0d ram_addr in reset", d), 32'(addr), 32'd0);
        chk($sformatf("dut%0d cpu_rdata in reset", d), crd, 32'd0);
        chk($sformatf("dut%0d dma_rdata in reset", d), drd, 32'd0);
    endtask

    // Monitor: sole owner of the pass/total counters.
    initial begin
        forever begin
            @(negedge Clock);
            if (Reset) begin
                rst_chk(0, busy0, own0, c0.ack, d0.ack, c0.rdata, d0.rdata, r0_addr, r0_we,
                        r0_re);
                rst_chk(1, busy1, own1, c1.ack, d1.ack, c1.rdata, d1.rdata, r1_addr, r1_we,
                        r1_re);
            end else begin
                mon_ack(0, c0.ack, d0.ack, own0, c0.rdata, d0.rdata);
                mon_ack(1, c1.ack, d1.ack, own1, c1.rdata, d1.rdata);
                mon_ram(0, r0_we, r0_re, r0_addr, r0_wdata);
                mon_ram(1, r1_we, r1_re, r1_addr, r1_wdata);
            end
            if (done) break;
        end
        chk("dut0 ack queue drained", 32'(ackq0.size()), 32'd0);
        chk("dut1 ack queue drained", 32'(ackq1.size()), 32'd0);
        chk("dut0 ram queue drained", 32'(ramq0.size()), 32'd0);
        chk("dut1 ram queue drained", 32'(ramq1.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    initial begin
        int c;
        {c0.req, c0.we, c0.addr, c0.wdata} = '0;
        {d0.req, d0.we, d0.addr, d0.wdata} = '0;
        {c1.req, c1.we, c1.addr, c1.wdata} = '0;
        {d1.req, d1.we, d1.addr, d1.wdata} = '0;
        step(2);
        Reset = 1'b0;
        step(2);

        // CPU write
        c = cyc;
        c0.we = 1'b1; c0.addr = 9'h005; c0.wdata = 32'hDEAD_BEEF; c0.req = 1'b1;
        exp_ram(0, c + 1, 1'b1, 9'h005, 32'hDEAD_BEEF);
        exp_ack(0, c + 2, 1'b0, 32'h0, 32'h0);
        step(2); c0.req = 1'b0; step(2);

        // DMA read, RD_LAT=2
        c = cyc;
        d0.we = 1'b0; d0.addr = 9'h010; d0.req = 1'b1;
        exp_ram(0, c + 1, 1'b0, 9'h010, 32'h0);
        exp_ack(0, c + 4, 1'b1, 32'h0, 32'h1234_5678);
        step(4); d0.req = 1'b0; step(2);

        // Round-robin with both held: CPU, DMA, CPU, DMA
        c = cyc;
        c0.we = 1'b1; c0.addr = 9'h020; c0.wdata = 32'hA5A5_0001;
        d0.we = 1'b1; d0.addr = 9'h021; d0.wdata = 32'h5A5A_0002;
        c0.req = 1'b1; d0.req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_ram(0, c + 1 + 6 * k, 1'b1, 9'h020, 32'hA5A5_0001);
            exp_ack(0, c + 2 + 6 * k, 1'b0, 32'h0, 32'h1234_5678);
            exp_ram(0, c + 4 + 6 * k, 1'b1, 9'h021, 32'h5A5A_0002);
            exp_ack(0, c + 5 + 6 * k, 1'b1, 32'h0, 32'h1234_5678);
        end
        step(11); c0.req = 1'b0; d0.req = 1'b0; step(2);

        // CPU reads back the first write
        c = cyc;
        c0.we = 1'b0; c0.addr = 9'h005; c0.req = 1'b1;
        exp_ram(0, c + 1, 1'b0, 9'h005, 32'h0);
        exp_ack(0, c + 4, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
        step(4); c0.req = 1'b0; step(2);

        // CPU drops req and scrambles inputs during ACCESS of a write
        c = cyc;
        c0.we = 1'b1; c0.addr = 9'h006; c0.wdata = 32'h0BAD_F00D; c0.req = 1'b1;
        exp_ram(0, c + 1, 1'b1, 9'h006, 32'h0BAD_F00D);
        exp_ack(0, c + 2, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
        step(1);
        c0.req = 1'b0; c0.we = 1'b0; c0.addr = 9'h007; c0.wdata = 32'hFFFF_FFFF;
        step(3);

        // DMA reads the dropped-req write back
        c = cyc;
        d0.we = 1'b0; d0.addr = 9'h006; d0.req = 1'b1;
        exp_ram(0, c + 1, 1'b0, 9'h006, 32'h0);
        exp_ack(0, c + 4, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        step(4); d0.req = 1'b0; step(2);

        // Reset during WAIT of a CPU read: no ack may follow
        c = cyc;
        c0.we = 1'b0; c0.addr = 9'h010; c0.req = 1'b1;
        exp_ram(0, c + 1, 1'b0, 9'h010, 32'h0);
        step(2);
        Reset = 1'b1; c0.req = 1'b0;
        step(1);
        Reset = 1'b0;
        step(6);

        // CPU priority with both held: CPU thrice, DMA only after cpu_req drops
        c = cyc;
        c1.we = 1'b1; c1.addr = 9'h040; c1.wdata = 32'h1111_0000;
        d1.we = 1'b1; d1.addr = 9'h041; d1.wdata = 32'h2222_0000;
        c1.req = 1'b1; d1.req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_ram(1, c + 1 + 3 * k, 1'b1, 9'h040, 32'h1111_0000);
            exp_ack(1, c + 2 + 3 * k, 1'b0, 32'h0, 32'h0);
        end
        exp_ram(1, c + 10, 1'b1, 9'h041, 32'h2222_0000);
        exp_ack(1, c + 11, 1'b1, 32'h0, 32'h0);
        step(8); c1.req = 1'b0; step(3); d1.req = 1'b0; step(2);

        // RD_LAT=1 reads on dut1
        c = cyc;
        c1.we = 1'b0; c1.addr = 9'h030; c1.req = 1'b1;
        exp_ram(1, c + 1, 1'b0, 9'h030, 32'h0);
        exp_ack(1, c + 3, 1'b0, 32'hCAFE_F00D, 32'h0);
        step(3); c1.req = 1'b0; step(2);

        c = cyc;
        d1.we = 1'b0; d1.addr = 9'h041; d1.req = 1'b1;
        exp_ram(1, c + 1, 1'b0, 9'h041, 32'h0);
        exp_ack(1, c + 3, 1'b1, 32'hCAFE_F00D, 32'h2222_0000);
        step(3); d1.req = 1'b0; step(4);

        done = 1'b1;
    end

endmodule
